// File: rtl/mvm_uart_rx.sv
// UART receiver: deserialises the rx line into BITS_PER_WORD-bit words and
// presents them on a valid/ready stream for the MVM input loader.
// Frame: start bit (0), BITS_PER_WORD data bits LSB-first, stop bit (1).
module mvm_uart_rx #(
  parameter int unsigned CLOCKS_PER_PULSE = 54,
  parameter int unsigned BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int unsigned CW       = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned IW       = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned HALF     = CLOCKS_PER_PULSE / 2;
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [BITS_PER_WORD-1:0] shreg;
  logic                     rx_m;
  logic                     rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM, bit timing, shift register and registered output slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      // A handshake empties the slot unless a new word is loaded below.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            // Line back high at mid start bit means a glitch, not a frame.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg[idx] <= rx_s;
            cnt        <= '0;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            // Return to IDLE on the sample cycle so back-to-back frames work.
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (!m_valid || m_ready) begin
              m_data  <= shreg;
              m_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_uart_rx.sv
// Directed bench for mvm_uart_rx: drives UART frames on rx and checks the
// received word stream and the frame_err / overflow pulses.
module tb_mvm_uart_rx;

  localparam int unsigned CPP = 54;
  localparam int unsigned BPW = 8;

  logic           clk;
  logic           rstn;
  logic           rx;
  logic [BPW-1:0] m_data;
  logic           m_valid;
  logic           m_ready;
  logic           frame_err;
  logic           overflow;

  int errors;
  int checks;
  int fe_cnt;
  int ov_cnt;
  logic [BPW-1:0] got[$];

  mvm_uart_rx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .frame_err(frame_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 ns after posedge; the monitor samples on negedge.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [BPW-1:0] nth(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  // stop_low > 0 holds the stop bit low for that many cycles (framing error).
  task automatic send_frame(input logic [BPW-1:0] d, input int stop_low);
    rx = 1'b0;
    cyc(CPP);
    for (int i = 0; i < int'(BPW); i++) begin
      rx = d[i];
      cyc(CPP);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      cyc(stop_low);
      rx = 1'b1;
      cyc(CPP - stop_low);
    end else begin
      rx = 1'b1;
      cyc(CPP);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cyc(3);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", m_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    rstn = 1'b1;
    cyc(CPP);
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'hA5, 0);
    cyc(10);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got.size()); end
    checks++; if (nth(0) !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", nth(0)); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", fe_cnt); end
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL single_ovf got %0d exp 0", ov_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b exp 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    send_frame(8'h3C, 0);
    cyc(10);
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
    checks++; if (nth(0) !== 8'h00) begin errors++; $display("FAIL b2b_w0 got %h exp 00", nth(0)); end
    checks++; if (nth(1) !== 8'hFF) begin errors++; $display("FAIL b2b_w1 got %h exp ff", nth(1)); end
    checks++; if (nth(2) !== 8'h3C) begin errors++; $display("FAIL b2b_w2 got %h exp 3c", nth(2)); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h5A, 32);
    cyc(CPP);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_pulse got %0d exp 1", fe_cnt); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL ferr_noword got %0d exp 0", got.size()); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b exp 0", m_valid); end
    send_frame(8'h11, 0);
    cyc(10);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL ferr_next_count got %0d exp 1", got.size()); end
    checks++; if (nth(0) !== 8'h11) begin errors++; $display("FAIL ferr_next_data got %h exp 11", nth(0)); end
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_next_pulse got %0d exp 1", fe_cnt); end
  endtask

  task automatic test_overflow();
    clear_mon();
    m_ready = 1'b0;
    send_frame(8'h12, 0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid1 got %b exp 1", m_valid); end
    checks++; if (m_data !== 8'h12) begin errors++; $display("FAIL ovf_data1 got %h exp 12", m_data); end
    send_frame(8'h34, 0);
    cyc(5);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid2 got %b exp 1", m_valid); end
    checks++; if (m_data !== 8'h12) begin errors++; $display("FAIL ovf_hold got %h exp 12", m_data); end
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovf_pulse got %0d exp 1", ov_cnt); end
    m_ready = 1'b1;
    cyc(5);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL ovf_hs_count got %0d exp 1", got.size()); end
    checks++; if (nth(0) !== 8'h12) begin errors++; $display("FAIL ovf_hs_data got %h exp 12", nth(0)); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid_drop got %b exp 0", m_valid); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    cyc(10);
    rx = 1'b1;
    cyc(CPP + 10);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL glitch_noword got %0d exp 0", got.size()); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_ferr got %0d exp 0", fe_cnt); end
    checks++; if (int'(dut.state) !== 0) begin errors++; $display("FAIL glitch_idle got %0d exp 0", int'(dut.state)); end
    send_frame(8'hC3, 0);
    cyc(10);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL glitch_next_count got %0d exp 1", got.size()); end
    checks++; if (nth(0) !== 8'hC3) begin errors++; $display("FAIL glitch_next_data got %h exp c3", nth(0)); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    fork
      send_frame(8'h77, 0);
      begin
        // Data bit 3 occupies line cycles 216..269 of the frame.
        cyc(230);
        rstn = 1'b0;
        cyc(20);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", m_data); end
        checks++; if (int'(dut.state) !== 0) begin errors++; $display("FAIL rstmid_idle got %0d exp 0", int'(dut.state)); end
      end
    join
    rstn = 1'b1;
    cyc(CPP);
    send_frame(8'h81, 0);
    cyc(10);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", got.size()); end
    checks++; if (nth(0) !== 8'h81) begin errors++; $display("FAIL rstmid_word got %h exp 81", nth(0)); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL rstmid_ferr got %0d exp 0", fe_cnt); end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    fe_cnt  = 0;
    ov_cnt  = 0;
    rx      = 1'b1;
    m_ready = 1'b1;
    rstn    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
